// File: rtl/rs_syndrome_sched.sv
// rtl/rs_syndrome_sched.sv - RS syndrome frame sequencer; define RS_SYN_SKID_EN for the result skid register
`timescale 1ns/1ps

module rs_syndrome_sched #(
  parameter int BEATS     = 16,
  parameter int NSYN      = 16,
  parameter int SLICE_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [127:0]             s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [127:0]             slc_data,
  output logic                     slc_valid,
  output logic [$clog2(BEATS)-1:0] slc_beat,
  output logic                     slc_clear,
  input  logic [8*NSYN-1:0]        slc_syn,
  output logic [8*NSYN-1:0]        syn_out,
  output logic                     syn_zero,
  output logic                     syn_err,
  output logic                     syn_valid,
  input  logic                     syn_ready
);

  localparam int BW = $clog2(BEATS);
  localparam int DW = $clog2(SLICE_LAT + 2);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            frame_err;

  logic            accept;
  logic [BW-1:0]   idx;
  logic            at_end;
  logic            frame_end;
  logic            len_err;
  logic            can_capture;

  assign accept = s_valid && s_ready;

  // Beat index of the incoming beat and the frame-closing / length-error decode
  always_comb begin
    idx       = (state == IDLE) ? '0 : beat_cnt;
    at_end    = (idx == BW'(BEATS - 1));
    frame_end = s_last || at_end;
    len_err   = s_last ^ at_end;
`ifdef RS_SYN_SKID_EN
    can_capture = !syn_valid || syn_ready;
`else
    can_capture = 1'b1;
`endif
  end

  // Frame sequencer: beat intake, slice drive, pipeline drain and result hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      frame_err <= 1'b0;
      s_ready   <= 1'b0;
      slc_data  <= '0;
      slc_valid <= 1'b0;
      slc_beat  <= '0;
      slc_clear <= 1'b0;
      syn_out   <= '0;
      syn_zero  <= 1'b0;
      syn_err   <= 1'b0;
      syn_valid <= 1'b0;
    end else begin
      slc_valid <= accept;
      slc_clear <= 1'b0;
      if (accept) begin
        slc_data <= s_data;
        slc_beat <= idx;
      end
      // A completed handshake empties the result register unless a capture below refills it
      if (syn_valid && syn_ready) begin
        syn_valid <= 1'b0;
      end
      case (state)
        IDLE, ACCUM: begin
          s_ready <= 1'b1;
          if (accept) begin
            beat_cnt <= idx + 1'b1;
            if (frame_end) begin
              frame_err <= len_err;
              drain_cnt <= DW'(SLICE_LAT + 1);
              s_ready   <= 1'b0;
              state     <= DRAIN;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
          end else if (can_capture) begin
            syn_out   <= slc_syn;
            syn_zero  <= (slc_syn == '0);
            syn_err   <= frame_err;
            syn_valid <= 1'b1;
`ifdef RS_SYN_SKID_EN
            // Slices are free again once the result sits in the output register
            slc_clear <= 1'b1;
            s_ready   <= 1'b1;
            state     <= IDLE;
`else
            state     <= HOLD;
`endif
          end
        end
        HOLD: begin
          if (syn_ready) begin
            slc_clear <= 1'b1;
            s_ready   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_syndrome_sched.sv
// tb/tb_rs_syndrome_sched.sv - scoreboard bench for rs_syndrome_sched with a GF(2^8) slice model
`timescale 1ns/1ps

module tb_rs_syndrome_sched;

  localparam int BEATS     = 16;
  localparam int NSYN      = 16;
  localparam int SLICE_LAT = 1;

  logic               clk;
  logic               rst_n;
  logic [127:0]       s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [127:0]       slc_data;
  logic               slc_valid;
  logic [3:0]         slc_beat;
  logic               slc_clear;
  logic [8*NSYN-1:0]  slc_syn;
  logic [8*NSYN-1:0]  syn_out;
  logic               syn_zero;
  logic               syn_err;
  logic               syn_valid;
  logic               syn_ready;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   beat;
    bit           first;
  } beat_t;

  typedef struct {
    logic [127:0] syn;
    bit           zero;
    bit           err;
    bit           chk_lat;
    int           t_last;
  } res_t;

  beat_t      beat_q[$];
  res_t       res_q[$];
  int         n_pass = 0;
  int         n_chk = 0;
  int         cyc = 0;
  int         beats_acc = 0;
  int         clr_since = 0;
  bit         after_rst = 1'b1;
  bit         prev_v = 1'b0;
  logic [7:0] exp_t [255];

  rs_syndrome_sched #(.BEATS(BEATS), .NSYN(NSYN), .SLICE_LAT(SLICE_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .slc_data(slc_data), .slc_valid(slc_valid), .slc_beat(slc_beat), .slc_clear(slc_clear),
    .slc_syn(slc_syn),
    .syn_out(syn_out), .syn_zero(syn_zero), .syn_err(syn_err),
    .syn_valid(syn_valid), .syn_ready(syn_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1d) : (x << 1);
    end
    return r;
  endfunction

  // Contribution of one beat to every syndrome: byte p = 16*beat+b weighted by alpha^(j*p)
  function automatic logic [8*NSYN-1:0] contrib(input logic [127:0] d, input logic [3:0] beat);
    logic [8*NSYN-1:0] r = '0;
    int e;
    for (int j = 0; j < NSYN; j++) begin
      for (int b = 0; b < 16; b++) begin
        e = (j * (16 * int'(beat) + b)) % 255;
        r[8*j +: 8] = r[8*j +: 8] ^ gf_mul(d[8*b +: 8], exp_t[e]);
      end
    end
    return r;
  endfunction

  // Slice array model: one register stage, cleared by rst_n or slc_clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slc_syn <= '0;
    else if (slc_clear) slc_syn <= '0;
    else if (slc_valid) slc_syn <= slc_syn ^ contrib(slc_data, slc_beat);
  end

  function automatic logic [127:0] pat_data(input int pat, input int k);
    logic [127:0] d = '0;
    if (k == 0) begin
      case (pat)
        1: d = 128'h01;
        2: d = 128'h0100;
        3: d = 128'h0101;
        4: d = 128'h05;
        default: d = '0;
      endcase
    end
    return d;
  endfunction

  // Hand-computed syndromes (poly 0x11d, alpha = 0x02), slice 0 in the low byte
  function automatic logic [127:0] pat_syn(input int pat);
    logic [127:0] s;
    case (pat)
      1: s = {16{8'h01}};
      2: s = 128'h26_13_87_cd_e8_74_3a_1d_80_40_20_10_08_04_02_01;
      3: s = 128'h27_12_86_cc_e9_75_3b_1c_81_41_21_11_09_05_03_00;
      4: s = {16{8'h05}};
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic put_beat(input logic [127:0] d, input bit last, input int k,
                          input bit push_res, input res_t r, output bit ok);
    beat_t b;
    res_t  rr;
    ok = 1'b0;
    s_data = d;
    s_last = last;
    s_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        b.data = d;
        b.beat = 4'(k % BEATS);
        b.first = (k == 0);
        beat_q.push_back(b);
        @(posedge clk);
        #1;
        beats_acc++;
        if (push_res) begin
          rr = r;
          rr.t_last = cyc;
          res_q.push_back(rr);
        end
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    if (!ok) check("beat_accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic send_frame(input int pat, input int nbeats, input bit has_last,
                            input bit chk_lat, input int gap_max);
    res_t r;
    bit   ok;
    r.syn = pat_syn(pat);
    r.zero = (r.syn == '0);
    r.err = !(has_last && nbeats == BEATS);
    r.chk_lat = chk_lat;
    r.t_last = 0;
    for (int k = 0; k < nbeats; k++) begin
      put_beat(pat_data(pat, k), has_last && (k == nbeats - 1), k, k == nbeats - 1, r, ok);
      if (!ok) return;
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (res_q.size() == 0 && beat_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 128'(0), 128'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 128'(s_ready), 128'(0));
    check({tag, "_slc_valid"}, 128'(slc_valid), 128'(0));
    check({tag, "_slc_clear"}, 128'(slc_clear), 128'(0));
    check({tag, "_slc_beat"}, 128'(slc_beat), 128'(0));
    check({tag, "_slc_data"}, slc_data, 128'(0));
    check({tag, "_syn_out"}, syn_out, 128'(0));
    check({tag, "_syn_flags"}, 128'({syn_valid, syn_zero, syn_err}), 128'(0));
  endtask

  // Monitor: compares every slice beat and every accepted result against the queues
  initial begin
    beat_t b;
    res_t  e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beat_q.delete();
        res_q.delete();
        after_rst = 1'b1;
        clr_since = 0;
        prev_v = 1'b0;
      end else begin
        if (slc_clear) clr_since++;
        if (slc_valid) begin
          if (beat_q.size() == 0) begin
            check("beat_unexpected", 128'(1), 128'(0));
          end else begin
            b = beat_q.pop_front();
            check("slc_data", slc_data, b.data);
            check("slc_beat", 128'(slc_beat), 128'(b.beat));
            if (b.first) begin
              check("clear_before_frame", 128'(clr_since), after_rst ? 128'(0) : 128'(1));
              clr_since = 0;
              after_rst = 1'b0;
            end
          end
        end
        if (syn_valid && !prev_v && res_q.size() > 0 && res_q[0].chk_lat)
          check("syn_valid_latency", 128'(cyc - res_q[0].t_last), 128'(SLICE_LAT + 2));
        prev_v = syn_valid;
        if (syn_valid && syn_ready) begin
          if (res_q.size() == 0) begin
            check("result_unexpected", 128'(1), 128'(0));
          end else begin
            e = res_q.pop_front();
            check("syn_out", syn_out, e.syn);
            check("syn_zero", 128'(syn_zero), 128'(e.zero));
            check("syn_err", 128'(syn_err), 128'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]   a;
    logic [127:0] held;
    int           base;
    bit           seen;
    bit           ok;
    res_t         dummy;

    a = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = a;
      a = a[7] ? ((a << 1) ^ 8'h1d) : (a << 1);
    end
    dummy = '{syn: '0, zero: 1'b0, err: 1'b0, chk_lat: 1'b0, t_last: 0};
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    syn_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_values("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_s_ready", 128'(s_ready), 128'(1));
    @(posedge clk);
    #1;

    // Clean frames with latency checks
    send_frame(0, 16, 1'b1, 1'b1, 0);
    send_frame(1, 16, 1'b1, 1'b1, 0);
    send_frame(2, 16, 1'b1, 1'b1, 0);
    send_frame(3, 16, 1'b1, 1'b1, 0);
    wait_idle();

    // Early s_last, missing s_last, then a clean frame restarting at beat 0
    send_frame(1, 10, 1'b1, 1'b1, 0);
    send_frame(2, 16, 1'b0, 1'b1, 0);
    send_frame(4, 16, 1'b1, 1'b1, 0);
    wait_idle();

    // Downstream stall of 20 cycles
    @(posedge clk);
    #1 syn_ready = 1'b0;
    send_frame(3, 16, 1'b1, 1'b0, 0);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (syn_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_result_seen", 128'(seen), 128'(1));
    held = syn_out;
    base = beats_acc;
    fork
      send_frame(4, 16, 1'b1, 1'b0, 0);
      begin
        for (int n = 0; n < 20; n++) begin
          @(negedge clk);
          check("stall_syn_out_stable", syn_out, held);
          check("stall_syn_valid", 128'(syn_valid), 128'(1));
`ifndef RS_SYN_SKID_EN
          check("stall_s_ready", 128'(s_ready), 128'(0));
`endif
        end
`ifdef RS_SYN_SKID_EN
        check("skid_beats_during_stall", 128'(beats_acc - base), 128'(16));
`endif
        @(posedge clk);
        #1 syn_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset in the middle of a frame, then a clean frame with no residue
    for (int k = 0; k < 7; k++) put_beat(pat_data(1, k), 1'b0, k, 1'b0, dummy, ok);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(2, 16, 1'b1, 1'b1, 0);
    wait_idle();

    // Eight frames with random s_valid gaps
    for (int f = 0; f < 8; f++) send_frame(f % 5, 16, 1'b1, 1'b0, 3);
    wait_idle();

    check("results_outstanding", 128'(res_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
